// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM command bus checker: tracks open banks, refresh and self-refresh state and
// flags tRP/tRFC/tXSR and bank-state violations. Optional SDRAM_ERR_STICKY_EN latches err.
module sdram_cmd_responder #(
    parameter int unsigned TRP_CYC  = 2,
    parameter int unsigned TRFC_CYC = 8,
    parameter int unsigned TXSR_CYC = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        sdram_init,
    input  logic        sdram_cke,
    input  logic [3:0]  sdram_cmd,
    input  logic [1:0]  sdram_ba,
    input  logic [11:0] sdram_addr,
    output logic [3:0]  bank_open,
    output logic        sr_active,
    output logic [12:0] ref_count,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        err_sticky
);

    localparam int unsigned MaxTrpTrfc = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int unsigned MaxCyc     = (MaxTrpTrfc > TXSR_CYC) ? MaxTrpTrfc : TXSR_CYC;
    localparam int unsigned CntW       = $clog2(MaxCyc) + 1;

    localparam logic [CntW-1:0] TrpLast  = CntW'(TRP_CYC - 1);
    localparam logic [CntW-1:0] TrfcLast = CntW'(TRFC_CYC - 1);
    localparam logic [CntW-1:0] TxsrLast = CntW'(TXSR_CYC - 1);

    localparam logic [12:0] RefMax = 13'h1FFF;

    typedef enum logic [2:0] {
        StIdle,
        StTrp,
        StTrfc,
        StSr,
        StTxsr
    } state_e;

    // Low three bits of the command with cs_n asserted.
    typedef enum logic [2:0] {
        CmdMrs = 3'b000,
        CmdRef = 3'b001,
        CmdPre = 3'b010,
        CmdAct = 3'b011,
        CmdWr  = 3'b100,
        CmdRd  = 3'b101,
        CmdBst = 3'b110,
        CmdNop = 3'b111
    } cmd_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bank_q, bank_d;
    logic            sr_q, sr_d;
    logic [12:0]     ref_q, ref_d;
    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;

    logic            cmd_quiet;
    logic            any_open;
    logic            err_set;
    logic [2:0]      err_val;
    logic            unused_addr;

    assign cmd_quiet   = sdram_cmd[3] | (sdram_cmd[2:0] == CmdNop);
    assign any_open    = |bank_q;
    assign unused_addr = ^{sdram_addr[11], sdram_addr[9:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        sr_d    = sr_q;
        ref_d   = ref_q;
        err_set = 1'b0;
        err_val = 3'd0;

        if (!sdram_init) begin
            state_d = StIdle;
            cnt_d   = '0;
            bank_d  = 4'b0000;
            sr_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!sdram_cmd[3]) begin
                        if (sdram_cke) begin
                            case (sdram_cmd[2:0])
                                CmdAct: begin
                                    if (bank_q[sdram_ba]) begin
                                        err_set = 1'b1;
                                        err_val = 3'd5;
                                    end else begin
                                        bank_d[sdram_ba] = 1'b1;
                                    end
                                end
                                CmdRd, CmdWr: begin
                                    if (!bank_q[sdram_ba]) begin
                                        err_set = 1'b1;
                                        err_val = 3'd6;
                                    end
                                end
                                CmdPre: begin
                                    if (sdram_addr[10]) begin
                                        bank_d = 4'b0000;
                                    end else begin
                                        bank_d[sdram_ba] = 1'b0;
                                    end
                                    state_d = StTrp;
                                    cnt_d   = '0;
                                end
                                CmdRef: begin
                                    if (any_open) begin
                                        err_set = 1'b1;
                                        err_val = 3'd4;
                                    end
                                    if (ref_q != RefMax) begin
                                        ref_d = ref_q + 13'd1;
                                    end
                                    state_d = StTrfc;
                                    cnt_d   = '0;
                                end
                                CmdMrs, CmdBst: begin
                                    if (any_open) begin
                                        err_set = 1'b1;
                                        err_val = 3'd7;
                                    end
                                end
                                default: ;
                            endcase
                        end else if (sdram_cmd[2:0] == CmdRef) begin
                            if (any_open) begin
                                err_set = 1'b1;
                                err_val = 3'd4;
                            end
                            sr_d    = 1'b1;
                            state_d = StSr;
                        end
                        // Any other command with cke low is power-down: ignored.
                    end
                end
                StTrp: begin
                    if (!cmd_quiet) begin
                        err_set = 1'b1;
                        err_val = 3'd1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TrpLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StTrfc: begin
                    if (!cmd_quiet) begin
                        err_set = 1'b1;
                        err_val = 3'd2;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TrfcLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StSr: begin
                    if (sdram_cke) begin
                        sr_d    = 1'b0;
                        ref_d   = 13'd0;
                        state_d = StTxsr;
                        cnt_d   = '0;
                    end
                end
                StTxsr: begin
                    if (!cmd_quiet) begin
                        err_set = 1'b1;
                        err_val = 3'd3;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TxsrLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        err_d  = err_set;
        code_d = err_set ? err_val : code_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bank_q  <= 4'b0000;
            sr_q    <= 1'b0;
            ref_q   <= 13'd0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            sr_q    <= sr_d;
            ref_q   <= ref_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bank_open = bank_q;
    assign sr_active = sr_q;
    assign ref_count = ref_q;
    assign err       = err_q;
    assign err_code  = code_q;

`ifdef SDRAM_ERR_STICKY_EN
    logic sticky_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sticky_q <= 1'b0;
        end else if (err_d) begin
            sticky_q <= 1'b1;
        end
    end

    assign err_sticky = sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Scoreboard bench for sdram_cmd_responder: directed command vectors with hand-computed outputs.
module tb_sdram_cmd_responder;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] DES = 4'b1111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] BST = 4'b0110;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        sdram_init;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic [3:0]  bank_open;
    logic        sr_active;
    logic [12:0] ref_count;
    logic        err;
    logic [2:0]  err_code;
    logic        err_sticky;

    typedef struct {
        string       nm;
        logic [3:0]  bank;
        logic        sr;
        logic [12:0] rc;
        logic        e;
        logic [2:0]  code;
        logic        sticky;
    } want_t;

    want_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  init_nxt = 1'b0;
    logic  sticky_m = 1'b0;

    sdram_cmd_responder dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sdram_init (sdram_init),
        .sdram_cke  (sdram_cke),
        .sdram_cmd  (sdram_cmd),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr),
        .bank_open  (bank_open),
        .sr_active  (sr_active),
        .ref_count  (ref_count),
        .err        (err),
        .err_code   (err_code),
        .err_sticky (err_sticky)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input string field, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s.%s: got %0d want %0d", nm, field, act, want);
        end
    endtask

    // Monitor: every registered output update is compared against the oldest expectation.
    always @(posedge sys_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            want_t w;
            w = exp_q.pop_front();
            chk(w.nm, "bank_open", int'(bank_open), int'(w.bank));
            chk(w.nm, "sr_active", int'(sr_active), int'(w.sr));
            chk(w.nm, "ref_count", int'(ref_count), int'(w.rc));
            chk(w.nm, "err", int'(err), int'(w.e));
            chk(w.nm, "err_code", int'(err_code), int'(w.code));
            chk(w.nm, "err_sticky", int'(err_sticky), int'(w.sticky));
        end
    end

    task automatic step(input string nm, input logic cke, input logic [3:0] cmd,
                        input logic [1:0] ba, input logic [11:0] addr,
                        input logic [3:0] eb, input logic es, input int er,
                        input logic ee, input logic [2:0] ec);
        want_t w;
        @(negedge sys_clk);
        sdram_init = init_nxt;
        sdram_cke  = cke;
        sdram_cmd  = cmd;
        sdram_ba   = ba;
        sdram_addr = addr;
`ifdef SDRAM_ERR_STICKY_EN
        if (ee) sticky_m = 1'b1;
`endif
        w.nm     = nm;
        w.bank   = eb;
        w.sr     = es;
        w.rc     = 13'(er);
        w.e      = ee;
        w.code   = ec;
        w.sticky = sticky_m;
        exp_q.push_back(w);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, "bank_open", int'(bank_open), 0);
        chk(nm, "sr_active", int'(sr_active), 0);
        chk(nm, "ref_count", int'(ref_count), 0);
        chk(nm, "err", int'(err), 0);
        chk(nm, "err_code", int'(err_code), 0);
        chk(nm, "err_sticky", int'(err_sticky), 0);
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        sdram_init = 1'b0;
        sdram_cke  = 1'b1;
        sdram_cmd  = DES;
        sdram_ba   = 2'd0;
        sdram_addr = 12'd0;
        repeat (3) @(negedge sys_clk);
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        init_nxt  = 1'b1;

        // Precharge-all, tRP honoured, auto-refresh, tRFC boundary.
        step("nop0", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 0);
        step("pre_all", 1, PRE, 0, 12'hFFF, 4'b0000, 0, 0, 0, 0);
        step("trp_nop1", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 0);
        step("trp_nop2", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 0);
        step("ref", 1, REF, 0, 12'h000, 4'b0000, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step("trfc_nop", 1, NOP, 0, 12'h000, 4'b0000, 0, 1, 0, 0);
        step("trfc_last_act", 1, ACT, 0, 12'h000, 4'b0000, 0, 1, 1, 2);
        step("act0", 1, ACT, 0, 12'h000, 4'b0001, 0, 1, 0, 2);

        // tRP violation, then legal on the following cycle.
        step("pre0", 1, PRE, 0, 12'h000, 4'b0000, 0, 1, 0, 2);
        step("trp_nop", 1, NOP, 0, 12'h000, 4'b0000, 0, 1, 0, 2);
        step("trp_viol_act", 1, ACT, 1, 12'h000, 4'b0000, 0, 1, 1, 1);
        step("act1", 1, ACT, 1, 12'h000, 4'b0010, 0, 1, 0, 1);

        // Bank-state errors.
        step("act1_again", 1, ACT, 1, 12'h000, 4'b0010, 0, 1, 1, 5);
        step("rd_closed", 1, RD, 2, 12'h000, 4'b0010, 0, 1, 1, 6);
        step("wr_open", 1, WR, 1, 12'h000, 4'b0010, 0, 1, 0, 6);
        step("mrs_open", 1, MRS, 0, 12'h000, 4'b0010, 0, 1, 1, 7);
        step("bst_open", 1, BST, 0, 12'h000, 4'b0010, 0, 1, 1, 7);
        step("act2", 1, ACT, 2, 12'h000, 4'b0110, 0, 1, 0, 7);

        // Self-refresh with banks open, exit, tXSR violation.
        step("sr_entry_open", 0, REF, 0, 12'h000, 4'b0110, 1, 1, 1, 4);
        for (int i = 0; i < 3; i++) step("sr_hold", 0, DES, 0, 12'h000, 4'b0110, 1, 1, 0, 4);
        step("sr_exit", 1, NOP, 0, 12'h000, 4'b0110, 0, 0, 0, 4);
        step("txsr_nop", 1, NOP, 0, 12'h000, 4'b0110, 0, 0, 0, 4);
        step("txsr_rd", 1, RD, 1, 12'h000, 4'b0110, 0, 0, 1, 3);
        for (int i = 0; i < 6; i++) step("txsr_nop", 1, NOP, 0, 12'h000, 4'b0110, 0, 0, 0, 3);
        step("pre_all2", 1, PRE, 3, 12'h400, 4'b0000, 0, 0, 0, 3);
        step("trp_nop", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 3);
        step("trp_nop", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 3);

        // Clean self-refresh: 20 held cycles, commands ignored, tXSR boundary.
        step("sr_entry", 0, REF, 0, 12'h000, 4'b0000, 1, 0, 0, 3);
        for (int i = 0; i < 20; i++) begin
            step("sr_hold2", 0, (i == 5) ? ACT : DES, 1, 12'h000, 4'b0000, 1, 0, 0, 3);
        end
        step("sr_exit2", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 3);
        for (int i = 0; i < 8; i++) step("txsr_nop2", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 3);
        step("ref_after_txsr", 1, REF, 0, 12'h000, 4'b0000, 0, 1, 0, 3);
        for (int i = 0; i < 8; i++) step("trfc_nop2", 1, NOP, 0, 12'h000, 4'b0000, 0, 1, 0, 3);

        // Power-down ignores commands.
        step("pd_act", 0, ACT, 3, 12'h000, 4'b0000, 0, 1, 0, 3);
        step("pd_exit", 1, NOP, 0, 12'h000, 4'b0000, 0, 1, 0, 3);
        step("act0b", 1, ACT, 0, 12'h000, 4'b0001, 0, 1, 0, 3);

        // Checking disabled while init is low; banks cleared.
        init_nxt = 1'b0;
        step("noinit_rd", 1, RD, 3, 12'h000, 4'b0000, 0, 1, 0, 3);
        step("noinit_mrs", 1, MRS, 0, 12'h000, 4'b0000, 0, 1, 0, 3);
        init_nxt = 1'b1;

        // Async reset in the middle of tRFC.
        step("ref2", 1, REF, 0, 12'h000, 4'b0000, 0, 2, 0, 3);
        step("trfc_nop3", 1, NOP, 0, 12'h000, 4'b0000, 0, 2, 0, 3);
        step("trfc_nop3", 1, NOP, 0, 12'h000, 4'b0000, 0, 2, 0, 3);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        sticky_m  = 1'b0;
        #1;
        chk_all_zero("rst_mid_trfc");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step("post_rst_nop", 1, NOP, 0, 12'h000, 4'b0000, 0, 0, 0, 0);
        step("post_rst_act", 1, ACT, 3, 12'h000, 4'b1000, 0, 0, 0, 0);
        step("post_rst_rd", 1, RD, 0, 12'h000, 4'b1000, 0, 0, 1, 6);

        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("end", "queue_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
